// File: rtl/ppa16.sv
// rtl/ppa16.sv - 16-bit Kogge-Stone adder with combinational and registered outputs
//
// Optional build macro PPA16_OVF_EN adds the signed-overflow outputs Ovf/Ovf_r.
// Prefix positions are indexed 0..16: index 0 is the carry-in (bit position -1)
// and index i+1 holds adder bit i.

module ppa16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] S,
  output logic        Cout,
  output logic [15:0] S_r,
  output logic        Cout_r,
  output logic        valid_r
`ifdef PPA16_OVF_EN
  ,
  output logic        Ovf,
  output logic        Ovf_r
`endif
);

  // One Kogge-Stone level: black cell at every position that has a partner
  // span below it; lower positions are already resolved and pass through.
  function automatic logic [33:0] ks_level(input logic [16:0] g_in,
                                           input logic [16:0] p_in,
                                           input int          span);
    logic [16:0] g_out;
    logic [16:0] p_out;
    g_out = g_in;
    p_out = p_in;
    for (int j = span; j < 17; j++) begin
      g_out[j] = g_in[j] | (p_in[j] & g_in[j-span]);
      p_out[j] = p_in[j] & p_in[j-span];
    end
    return {g_out, p_out};
  endfunction

  // Grey-cell column: only the group generate is needed, the group propagate
  // of a range reaching the carry-in position is always zero.
  function automatic logic [16:0] ks_grey(input logic [16:0] g_in,
                                          input logic [16:0] p_in,
                                          input int          span);
    logic [16:0] g_out;
    g_out = g_in;
    for (int j = span; j < 17; j++) begin
      g_out[j] = g_in[j] | (p_in[j] & g_in[j-span]);
    end
    return g_out;
  endfunction

  logic [15:0] p_bit;
  logic [16:0] g0, p0;
  logic [16:0] g1, p1;
  logic [16:0] g2, p2;
  logic [16:0] g3, p3;
  logic [16:0] g4, p4;
  logic [16:0] carry;

  // Bit-level propagate/generate; carry-in enters as a pure generate at index 0
  always_comb begin
    p_bit = A ^ B;
    g0    = {A & B, Cin};
    p0    = {p_bit, 1'b0};
  end

  // Prefix level 1 (span 1)
  always_comb begin
    {g1, p1} = ks_level(g0, p0, 1);
  end

  // Prefix level 2 (span 2)
  always_comb begin
    {g2, p2} = ks_level(g1, p1, 2);
  end

  // Prefix level 3 (span 4)
  always_comb begin
    {g3, p3} = ks_level(g2, p2, 4);
  end

  // Prefix level 4 (span 8); after this every index 0..15 spans down to Cin
  always_comb begin
    {g4, p4} = ks_level(g3, p3, 8);
  end

  // Index 16 spans bits 15..0 after four levels; one grey cell folds in Cin
  // to form the carry-out. carry[i] is the carry into bit i, carry[16] is Cout.
  always_comb begin
    carry = ks_grey(g4, p4, 16);
  end

  // Sum and carry-out are purely combinational on A/B/Cin
  always_comb begin
    S    = p_bit ^ carry[15:0];
    Cout = carry[16];
  end

`ifdef PPA16_OVF_EN
  // Signed overflow: carry into the sign bit differs from the carry out of it
  always_comb begin
    Ovf = carry[15] ^ carry[16];
  end
`endif

  logic [15:0] s_r_d, s_r_q;
  logic        cout_r_d, cout_r_q;
  logic        valid_r_d, valid_r_q;
`ifdef PPA16_OVF_EN
  logic        ovf_r_d, ovf_r_q;
`endif

  // Next-state for the output register: capture every cycle, no handshake
  always_comb begin
    s_r_d     = S;
    cout_r_d  = Cout;
    valid_r_d = 1'b1;
`ifdef PPA16_OVF_EN
    ovf_r_d   = Ovf;
`endif
  end

  // Output register stage, cleared asynchronously by rst_n
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r_q     <= 16'h0000;
      cout_r_q  <= 1'b0;
      valid_r_q <= 1'b0;
`ifdef PPA16_OVF_EN
      ovf_r_q   <= 1'b0;
`endif
    end else begin
      s_r_q     <= s_r_d;
      cout_r_q  <= cout_r_d;
      valid_r_q <= valid_r_d;
`ifdef PPA16_OVF_EN
      ovf_r_q   <= ovf_r_d;
`endif
    end
  end

  assign S_r     = s_r_q;
  assign Cout_r  = cout_r_q;
  assign valid_r = valid_r_q;
`ifdef PPA16_OVF_EN
  assign Ovf_r   = ovf_r_q;
`endif

endmodule

// File: tb/tb_ppa16.sv
// tb/tb_ppa16.sv - directed and swept self-checking bench for ppa16

module tb_ppa16;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        Cin;
  logic [15:0] S;
  logic        Cout;
  logic [15:0] S_r;
  logic        Cout_r;
  logic        valid_r;
`ifdef PPA16_OVF_EN
  logic        Ovf;
  logic        Ovf_r;
`endif

  int checks = 0;
  int errors = 0;

  ppa16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .Cin     (Cin),
    .S       (S),
    .Cout    (Cout),
    .S_r     (S_r),
    .Cout_r  (Cout_r),
    .valid_r (valid_r)
`ifdef PPA16_OVF_EN
    ,
    .Ovf     (Ovf),
    .Ovf_r   (Ovf_r)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one vector between edges, check combinational then registered result
  task automatic vec(input string tag, input logic [15:0] a, input logic [15:0] b,
                     input logic ci, input logic [15:0] exp_s, input logic exp_c,
                     input logic exp_ovf);
    @(negedge clk);
    A = a; B = b; Cin = ci;
    #1;
    check({tag, " S"}, 32'(S), 32'(exp_s));
    check({tag, " Cout"}, 32'(Cout), 32'(exp_c));
`ifdef PPA16_OVF_EN
    check({tag, " Ovf"}, 32'(Ovf), 32'(exp_ovf));
`endif
    @(posedge clk);
    #1;
    check({tag, " S_r"}, 32'(S_r), 32'(exp_s));
    check({tag, " Cout_r"}, 32'(Cout_r), 32'(exp_c));
    check({tag, " valid_r"}, 32'(valid_r), 32'(1));
`ifdef PPA16_OVF_EN
    check({tag, " Ovf_r"}, 32'(Ovf_r), 32'(exp_ovf));
`endif
    if (exp_ovf === 1'bx) $display("unreachable");
  endtask

  initial begin
    logic [16:0] sum;
    logic        ovf;
    logic [15:0] ra, rb;
    logic        rc;

    rst_n = 1'b0;
    A = 16'h0000; B = 16'h0000; Cin = 1'b0;

    // Reset state, including across a clock edge
    #12;
    check("rst S_r", 32'(S_r), 32'h0);
    check("rst Cout_r", 32'(Cout_r), 32'h0);
    check("rst valid_r", 32'(valid_r), 32'h0);
    check("rst S", 32'(S), 32'h0);

    // First result after release: valid only after the first edge
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'h1234; B = 16'h4321; Cin = 1'b0;
    #1;
    check("first S", 32'(S), 32'h5555);
    check("first Cout", 32'(Cout), 32'h0);
    check("first valid_r pre-edge", 32'(valid_r), 32'h0);
    @(posedge clk);
    #1;
    check("first S_r", 32'(S_r), 32'h5555);
    check("first Cout_r", 32'(Cout_r), 32'h0);
    check("first valid_r", 32'(valid_r), 32'h1);

    // Hand-computed boundary vectors
    vec("ffff+1",       16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    vec("ffff+0+cin",   16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    vec("8000+8000",    16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    vec("7fff+1",       16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    vec("0+0+cin",      16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
    vec("ffff+ffff+1",  16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    vec("5555+5555",    16'h5555, 16'h5555, 1'b0, 16'hAAAA, 1'b0, 1'b1);
    vec("00ff+0001",    16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    // Random sweep, back-to-back: new inputs every cycle
    for (int i = 0; i < 1024; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = (i >= 512);
      sum = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      ovf = (ra[15] == rb[15]) && (sum[15] != ra[15]);
      @(negedge clk);
      A = ra; B = rb; Cin = rc;
      #1;
      check($sformatf("sweep%0d S", i), 32'(S), 32'(sum[15:0]));
      check($sformatf("sweep%0d Cout", i), 32'(Cout), 32'(sum[16]));
`ifdef PPA16_OVF_EN
      check($sformatf("sweep%0d Ovf", i), 32'(Ovf), 32'(ovf));
`endif
      @(posedge clk);
      #1;
      check($sformatf("sweep%0d S_r", i), 32'(S_r), 32'(sum[15:0]));
      check($sformatf("sweep%0d Cout_r", i), 32'(Cout_r), 32'(sum[16]));
    end

    // Asynchronous reset mid-cycle; combinational path keeps tracking inputs
    @(negedge clk);
    A = 16'hAAAA; B = 16'h5555; Cin = 1'b1;
    @(posedge clk);
    #1;
    check("prerst S_r", 32'(S_r), 32'h0000);
    check("prerst Cout_r", 32'(Cout_r), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async S_r", 32'(S_r), 32'h0000);
    check("async Cout_r", 32'(Cout_r), 32'h0);
    check("async valid_r", 32'(valid_r), 32'h0);
    check("async S", 32'(S), 32'h0000);
    check("async Cout", 32'(Cout), 32'h1);

    // Reset with a non-zero registered sum must also clear at once
    @(negedge clk);
    rst_n = 1'b1;
    A = 16'h1234; B = 16'h4321; Cin = 1'b1;
    #1;
    check("rel valid_r pre-edge", 32'(valid_r), 32'h0);
    @(posedge clk);
    #1;
    check("rel valid_r", 32'(valid_r), 32'h1);
    check("rel S_r", 32'(S_r), 32'h5556);
    #2;
    rst_n = 1'b0;
    #1;
    check("async2 S_r", 32'(S_r), 32'h0000);
    check("async2 S", 32'(S), 32'h5556);
    @(negedge clk);
    rst_n = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
